// File: rtl/sbox_lane_scheduler_if.sv
// Handshake bundle for the shared S-box lane: a state (SubBytes) channel,
// a word (SubWord) channel and the lane grant observability pins.
interface sbox_lane_scheduler_if #(
    parameter int N = 4
);
    logic [0:N-1][0:N-1][7:0] st_in;
    logic                     st_in_valid;
    logic                     st_in_ready;
    logic [0:N-1][0:N-1][7:0] st_out;
    logic                     st_out_valid;
    logic                     st_out_ready;

    logic [0:N-1][7:0]        wd_in;
    logic                     wd_in_valid;
    logic                     wd_in_ready;
    logic [0:N-1][7:0]        wd_out;
    logic                     wd_out_valid;
    logic                     wd_out_ready;

    logic                     gnt_st;
    logic                     gnt_wd;

    modport master (
        output st_in, st_in_valid, st_out_ready,
        output wd_in, wd_in_valid, wd_out_ready,
        input  st_in_ready, st_out, st_out_valid,
        input  wd_in_ready, wd_out, wd_out_valid,
        input  gnt_st, gnt_wd
    );

    modport slave (
        input  st_in, st_in_valid, st_out_ready,
        input  wd_in, wd_in_valid, wd_out_ready,
        output st_in_ready, st_out, st_out_valid,
        output wd_in_ready, wd_out, wd_out_valid,
        output gnt_st, gnt_wd
    );
endinterface

// File: rtl/sbox_lane_scheduler.sv
// One N-byte AES S-box lane time-shared between a column-serial SubBytes
// request and a single-word SubWord request, with alternating priority.

module sbox_lane_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; 0 maps to 0.
    always_comb begin
        sq  = a_i;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module sbox_lane_scheduler #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sbox_lane_scheduler_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} st_state_e;
    typedef enum logic [1:0] {W_IDLE, W_PEND, W_DONE} wd_state_e;

    st_state_e                st_state_q;
    wd_state_e                wd_state_q;
    logic [0:N-1][0:N-1][7:0] st_q;
    logic [0:N-1][0:N-1][7:0] st_res_q;
    logic [0:N-1][7:0]        wd_q;
    logic [0:N-1][7:0]        wd_res_q;
    logic [CW-1:0]            col_q;
    logic                     last_wd_q;
    logic                     st_in_ready_q;
    logic                     st_out_valid_q;
    logic                     wd_in_ready_q;
    logic                     wd_out_valid_q;

    logic                     st_req;
    logic                     wd_req;
    logic                     gnt_st;
    logic                     gnt_wd;
    logic [0:N-1][7:0]        lane_in;
    logic [0:N-1][7:0]        lane_out;

    // A pending word loses only to the state op right after it was served,
    // so neither requester can be starved.
    always_comb begin
        st_req = (st_state_q == S_RUN);
        wd_req = (wd_state_q == W_PEND);
        gnt_wd = wd_req && (!st_req || !last_wd_q);
        gnt_st = st_req && !gnt_wd;
    end

    always_comb begin
        lane_in = wd_q;
        if (!gnt_wd) begin
            for (int r = 0; r < N; r++) lane_in[r] = st_q[r][col_q];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        sbox_lane_sbox u_sbox (
            .a_i (lane_in[g]),
            .y_o (lane_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_state_q     <= S_IDLE;
            st_q           <= '0;
            st_res_q       <= '0;
            col_q          <= '0;
            st_in_ready_q  <= 1'b0;
            st_out_valid_q <= 1'b0;
        end else begin
            case (st_state_q)
                S_IDLE: begin
                    st_in_ready_q <= 1'b1;
                    if (bus.st_in_valid && st_in_ready_q) begin
                        st_q          <= bus.st_in;
                        col_q         <= '0;
                        st_in_ready_q <= 1'b0;
                        st_state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (gnt_st) begin
                        for (int r = 0; r < N; r++) st_res_q[r][col_q] <= lane_out[r];
                        col_q <= col_q + 1'b1;
                        if (col_q == CW'(N - 1)) begin
                            st_out_valid_q <= 1'b1;
                            st_state_q     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.st_out_ready) begin
                        st_out_valid_q <= 1'b0;
                        st_in_ready_q  <= 1'b1;
                        st_state_q     <= S_IDLE;
                    end
                end
                default: st_state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_state_q     <= W_IDLE;
            wd_q           <= '0;
            wd_res_q       <= '0;
            last_wd_q      <= 1'b0;
            wd_in_ready_q  <= 1'b0;
            wd_out_valid_q <= 1'b0;
        end else begin
            last_wd_q <= gnt_wd;
            case (wd_state_q)
                W_IDLE: begin
                    wd_in_ready_q <= 1'b1;
                    if (bus.wd_in_valid && wd_in_ready_q) begin
                        wd_q          <= bus.wd_in;
                        wd_in_ready_q <= 1'b0;
                        wd_state_q    <= W_PEND;
                    end
                end
                W_PEND: begin
                    if (gnt_wd) begin
                        wd_res_q       <= lane_out;
                        wd_out_valid_q <= 1'b1;
                        wd_state_q     <= W_DONE;
                    end
                end
                W_DONE: begin
                    if (bus.wd_out_ready) begin
                        wd_out_valid_q <= 1'b0;
                        wd_in_ready_q  <= 1'b1;
                        wd_state_q     <= W_IDLE;
                    end
                end
                default: wd_state_q <= W_IDLE;
            endcase
        end
    end

    assign bus.st_in_ready  = st_in_ready_q;
    assign bus.st_out       = st_res_q;
    assign bus.st_out_valid = st_out_valid_q;
    assign bus.wd_in_ready  = wd_in_ready_q;
    assign bus.wd_out       = wd_res_q;
    assign bus.wd_out_valid = wd_out_valid_q;
    assign bus.gnt_st       = gnt_st;
    assign bus.gnt_wd       = gnt_wd;
endmodule

// File: tb/tb_sbox_lane_scheduler.sv
// Bench for sbox_lane_scheduler: word vector table, FIPS-197 state, contention,
// back-pressure, word bursts and mid-operation reset, with a result scoreboard.
module tb_sbox_lane_scheduler;
    localparam int N = 4;
    typedef logic [0:N-1][0:N-1][7:0] st_t;
    typedef logic [0:N-1][7:0]        wd_t;
    typedef struct {
        wd_t din;
        wd_t exp;
    } wvec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    st_t  st_exp_q[$];
    wd_t  wd_exp_q[$];
    st_t  cur_st_exp;
    wd_t  cur_wd_exp;
    logic acc_st = 1'b0;
    logic acc_wd = 1'b0;

    sbox_lane_scheduler_if #(.N(N)) bus();

    sbox_lane_scheduler #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [7:0] bgmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    // Reference S-box: brute-force inverse search, then the bitwise affine map.
    function automatic logic [7:0] bsbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] o;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) if (bgmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            o[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
                   inv[(i + 7) % 8] ^ c[i];
        return o;
    endfunction

    function automatic st_t model_state(input st_t s);
        st_t m;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) m[r][c] = bsbox(s[r][c]);
        return m;
    endfunction

    function automatic wd_t model_word(input wd_t w);
        wd_t m;
        for (int r = 0; r < N; r++) m[r] = bsbox(w[r]);
        return m;
    endfunction

    function automatic st_t mk_state(input logic [127:0] cols);
        st_t s;
        for (int c = 0; c < N; c++)
            for (int r = 0; r < N; r++) s[r][c] = cols[127 - 32 * c - 8 * r -: 8];
        return s;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) s[r][c] = 8'($urandom);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected one within bound", nm);
    endtask

    // One clock: sample handshakes and run the scoreboard on the falling edge,
    // then return 1 ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        acc_st = rst_n && bus.st_in_valid && bus.st_in_ready;
        acc_wd = rst_n && bus.wd_in_valid && bus.wd_in_ready;
        if (acc_st) st_exp_q.push_back(cur_st_exp);
        if (acc_wd) wd_exp_q.push_back(cur_wd_exp);
        if (rst_n) begin
            if (bus.gnt_st && bus.gnt_wd) begin
                errors++;
                checks++;
                $display("FAIL gnt_exclusive: got both grants expected at most one");
            end
            if (bus.st_out_valid && bus.st_out_ready) begin
                if (st_exp_q.size() == 0) fail("st_out_unexpected");
                else chk("st_out", bus.st_out, st_exp_q.pop_front());
            end
            if (bus.wd_out_valid && bus.wd_out_ready) begin
                if (wd_exp_q.size() == 0) fail("wd_out_unexpected");
                else chk("wd_out", 128'(bus.wd_out), 128'(wd_exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_st(input st_t s, input st_t e);
        int n;
        bus.st_in       = s;
        cur_st_exp      = e;
        bus.st_in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_st && n < 50);
        bus.st_in_valid = 1'b0;
        if (!acc_st) fail("st_accept_timeout");
    endtask

    task automatic send_wd(input wd_t w, input wd_t e);
        int n;
        bus.wd_in       = w;
        cur_wd_exp      = e;
        bus.wd_in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_wd && n < 50);
        bus.wd_in_valid = 1'b0;
        if (!acc_wd) fail("wd_accept_timeout");
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((st_exp_q.size() != 0 || wd_exp_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        if (st_exp_q.size() != 0 || wd_exp_q.size() != 0) fail("drain_timeout");
    endtask

    initial begin
        wvec_t wtab[5];
        st_t   s;
        st_t   e;
        wd_t   w;
        wd_t   we;
        int    n;
        int    left;
        int    ngw;
        int    t_acc;
        int    t_done;
        logic  prev_g;
        logic  consec;
        logic  done;

        wtab[0] = '{din: 32'hcf4f3c09, exp: 32'h8a84eb01};
        wtab[1] = '{din: 32'h00530053, exp: 32'h63ed63ed};
        wtab[2] = '{din: 32'h00000000, exp: 32'h63636363};
        wtab[3] = '{din: 32'hffffffff, exp: 32'h16161616};
        wtab[4] = '{din: 32'h01020304, exp: 32'h7c777bf2};

        bus.st_in        = '0;
        bus.st_in_valid  = 1'b0;
        bus.st_out_ready = 1'b1;
        bus.wd_in        = '0;
        bus.wd_in_valid  = 1'b0;
        bus.wd_out_ready = 1'b1;

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_st_out", bus.st_out, 128'h0);
        chk("reset_wd_out", 128'(bus.wd_out), 128'h0);
        chk("reset_flags", 128'({bus.st_out_valid, bus.wd_out_valid, bus.st_in_ready,
                                 bus.wd_in_ready, bus.gnt_st, bus.gnt_wd}), 128'(6'b0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("ready_after_reset", 128'({bus.st_in_ready, bus.wd_in_ready}), 128'(2'b11));

        // FIPS-197 round-1 SubBytes, uncontended timing
        s = mk_state(128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);
        e = mk_state(128'hd42711ae_e0bf98f1_b8b45de5_1e415230);
        send_st(s, e);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("fips_gnt_c%0d", i),
                128'({bus.gnt_st, bus.gnt_wd, bus.st_out_valid}), 128'(3'b100));
            tick();
        end
        chk("fips_valid_lat", 128'({bus.st_out_valid, bus.gnt_st}), 128'(2'b10));
        wait_drain();

        // Word table, uncontended timing
        for (int i = 0; i < 5; i++) begin
            send_wd(wtab[i].din, wtab[i].exp);
            chk($sformatf("wd%0d_gnt", i), 128'({bus.gnt_wd, bus.wd_out_valid}), 128'(2'b10));
            tick();
            chk($sformatf("wd%0d_valid_lat", i), 128'({bus.wd_out_valid, bus.gnt_wd}),
                128'(2'b10));
            wait_drain();
        end

        // Contention: state at T, word at T+1
        s = rand_state();
        send_st(s, model_state(s));
        chk("cont_t1", 128'({bus.gnt_st, bus.gnt_wd}), 128'(2'b10));
        w = 32'h3c4fcf09;
        send_wd(w, model_word(w));
        chk("cont_t2", 128'({bus.gnt_st, bus.gnt_wd}), 128'(2'b01));
        for (int i = 3; i <= 5; i++) begin
            tick();
            chk($sformatf("cont_t%0d", i),
                128'({bus.gnt_st, bus.gnt_wd, bus.st_out_valid}), 128'(3'b100));
        end
        tick();
        chk("cont_valid_t6", 128'(bus.st_out_valid), 128'(1'b1));
        wait_drain();

        // Back-pressure on both outputs
        bus.st_out_ready = 1'b0;
        bus.wd_out_ready = 1'b0;
        s  = rand_state();
        e  = model_state(s);
        w  = wd_t'($urandom);
        we = model_word(w);
        send_st(s, e);
        send_wd(w, we);
        n = 0;
        while (!(bus.st_out_valid && bus.wd_out_valid) && n < 20) begin
            tick();
            n++;
        end
        if (!(bus.st_out_valid && bus.wd_out_valid)) fail("bp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_st_hold%0d", i), bus.st_out, e);
            chk($sformatf("bp_wd_hold%0d", i), 128'(bus.wd_out), 128'(we));
            chk($sformatf("bp_flags%0d", i), 128'({bus.st_out_valid, bus.wd_out_valid,
                bus.st_in_ready, bus.wd_in_ready}), 128'(4'b1100));
            tick();
        end
        bus.st_out_ready = 1'b1;
        bus.wd_out_ready = 1'b1;
        tick();
        chk("bp_release", 128'({bus.st_in_ready, bus.wd_in_ready, bus.st_out_valid,
                                bus.wd_out_valid}), 128'(4'b1100));
        s = rand_state();
        w = wd_t'($urandom);
        bus.st_in       = s;
        cur_st_exp      = model_state(s);
        bus.wd_in       = w;
        cur_wd_exp      = model_word(w);
        bus.st_in_valid = 1'b1;
        bus.wd_in_valid = 1'b1;
        tick();
        bus.st_in_valid = 1'b0;
        bus.wd_in_valid = 1'b0;
        chk("both_accept", 128'({acc_st, acc_wd}), 128'(2'b11));
        wait_drain();

        // Word burst during a state op
        s = rand_state();
        send_st(s, model_state(s));
        t_acc = cyc - 1;
        left  = 3;
        w     = wd_t'($urandom);
        bus.wd_in       = w;
        cur_wd_exp      = model_word(w);
        bus.wd_in_valid = 1'b1;
        prev_g = 1'b0;
        consec = 1'b0;
        done   = 1'b0;
        ngw    = 0;
        t_done = 0;
        n      = 0;
        while (!(done && left == 0) && n < 80) begin
            if (bus.gnt_wd && prev_g) consec = 1'b1;
            prev_g = bus.gnt_wd;
            if (!done && bus.gnt_wd) ngw++;
            if (!done && bus.st_out_valid) begin
                done   = 1'b1;
                t_done = cyc;
            end
            tick();
            n++;
            if (acc_wd) begin
                left--;
                if (left == 0) bus.wd_in_valid = 1'b0;
                else begin
                    w          = wd_t'($urandom);
                    bus.wd_in  = w;
                    cur_wd_exp = model_word(w);
                end
            end
        end
        bus.wd_in_valid = 1'b0;
        if (!(done && left == 0)) fail("burst_timeout");
        chk("burst_no_consecutive_gnt_wd", 128'(consec), 128'(1'b0));
        chk("burst_words_interleaved", 128'(ngw > 0), 128'(1'b1));
        chk("burst_state_bound", 128'((t_done - t_acc) <= (N + ngw + 1)), 128'(1'b1));
        wait_drain();

        // Reset during column 2 with a word pending
        s = rand_state();
        send_st(s, model_state(s));
        tick();
        w = 32'h11223344;
        send_wd(w, model_word(w));
        chk("pre_reset_gnt", 128'({bus.gnt_st, bus.gnt_wd}), 128'(2'b01));
        rst_n = 1'b0;
        #1;
        chk("midrst_st_out", bus.st_out, 128'h0);
        chk("midrst_wd_out", 128'(bus.wd_out), 128'h0);
        chk("midrst_flags", 128'({bus.st_out_valid, bus.wd_out_valid, bus.st_in_ready,
                                  bus.wd_in_ready, bus.gnt_st, bus.gnt_wd}), 128'(6'b0));
        st_exp_q.delete();
        wd_exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("postrst_flags", 128'({bus.st_out_valid, bus.wd_out_valid, bus.st_in_ready,
                                   bus.wd_in_ready, bus.gnt_st, bus.gnt_wd}), 128'(6'b001100));
        s = rand_state();
        send_st(s, model_state(s));
        repeat (N) tick();
        chk("postrst_valid_lat", 128'({bus.st_out_valid, bus.wd_out_valid}), 128'(2'b10));
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
